bubble_turn_sequencer: RTL and testbench
========================================

Name: bubble_turn_sequencer

Overview:
- Sequences one two-player Connect-the-Bubbles match on an 8x8 board: accepts move requests, checks cell occupancy, writes the red/blue occupancy planes, and runs a multi-cycle win scan. It then updates scores, alternates the turn, and holds between rounds.
- Sits between the move-entry/cursor logic (upstream) and the LED-matrix driver and score display (downstream).
- Cell index = {row[2:0], col[2:0]}, so cell 8*row+col.

Parameters:
- CONNECT, 4, run length that wins; legal range 2..8.
- MATCH_POINTS, 3, round wins needed to win the match; legal range 1..3.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- move_valid  in  1  move request; must stay high with move_cell stable until move_ready.
- move_cell  in  6  requested cell index.
- move_ready  out  1  high only in IDLE; a move is taken on any edge where move_valid && move_ready.
- move_reject  out  1  one-cycle pulse: the taken move hit an occupied cell.
- new_round  in  1  level; sampled only in ROUND_END and MATCH_END.
- red  out  64  red occupancy plane.
- blue  out  64  blue occupancy plane.
- turn  out  1  0 = red (player 1) to move, 1 = blue (player 2) to move.
- p1_score  out  2  red round wins.
- p2_score  out  2  blue round wins.
- round_win  out  2  one-cycle pulse: 01 = red won the round, 10 = blue won, 11 = draw; 00 otherwise.
- match_over  out  1  high while in MATCH_END.
- busy  out  1  high in PLACE, SCAN and RESOLVE.

Behaviour:
- Reset (asynchronous, immediate): state IDLE; red, blue, p1_score, p2_score = 0; turn = 0; move_ready = 1; every pulse output, match_over and busy = 0. Reset during SCAN aborts the scan with no score change.
- States: IDLE, PLACE, SCAN, RESOLVE, ROUND_END, MATCH_END.
- IDLE, handshake taken on edge T:
  - Cell occupied (red|blue bit set): move_reject = 1 for cycle T+1; stay IDLE; board and turn unchanged.
  - Cell empty: latch move_cell; go to PLACE.
- PLACE (edge T+1): set bit move_cell in the plane selected by turn (blue if turn = 1, red if 0). Clear the scan index and the win flag. Go to SCAN.
- SCAN: one cell index i per cycle, 0..63; 64 cycles, edges T+2..T+65. Scans only the plane of the player who just moved.
  - Horizontal hit: col(i) <= 8-CONNECT and bits i .. i+CONNECT-1 all set.
  - Vertical hit: row(i) <= 8-CONNECT and bits i, i+8, ... i+8*(CONNECT-1) all set.
  - No wrap across a row edge. No diagonals. Any hit sets the sticky win flag. No early exit: the scan length is always 64.
- RESOLVE (edge T+66):
  - Win: increment the mover's score, saturating at 3. Pulse round_win for the mover. Set turn = other player, so the loser starts the next round. Go to MATCH_END if the new score == MATCH_POINTS, else ROUND_END.
  - No win, board full ((red|blue) == all ones): round_win = 11; turn = 0; go to ROUND_END.
  - Otherwise: toggle turn; go to IDLE. move_ready is high again from T+67.
- ROUND_END: planes hold, to be shown on the display. When new_round = 1: clear red and blue, go to IDLE. Scores kept.
- MATCH_END: match_over = 1. When new_round = 1: clear planes and both scores, turn = 0, go to IDLE.
- move_valid is ignored outside IDLE. The win check uses the plane value after the PLACE write.

Test Plan:
- Reset, then red moves cell 10 -> red = 0x400 after PLACE; round_win = 00 at T+66; turn = 1 and move_ready = 1 at T+67.
- Red takes cell 10, then blue requests cell 10 -> move_reject pulse one cycle; blue unchanged; turn stays 1; busy never asserts.
- Red plays cells 0,1,2,3 with blue interleaved on 8,9,10 -> on red's 4th move round_win = 01 and p1_score = 1; state ROUND_END; turn = 1; new_round clears red and blue to 0.
- Wrap check: red holds cells 6,7,8,9 (adjacent indices, different rows) -> no win. Vertical check: blue holds 3,11,19,27 -> round_win = 10.
- Blue wins three rounds (MATCH_POINTS = 3) -> match_over = 1 with p2_score = 3; new_round -> scores 0, turn = 0, IDLE.
- Fill all 64 cells with no 4-run (rows in pattern RRBBRRBB, alternately shifted by 2) -> round_win = 11 on the last move. Separately, assert reset mid-SCAN -> all outputs at reset values immediately.

Source files
------------

// File: rtl/bubble_turn_sequencer.sv
// Turn sequencer for an 8x8 two-player bubble match: takes moves, marks the
// mover's occupancy plane, scans that plane for a winning run, then scores,
// alternates the turn and parks between rounds until new_round.
module bubble_turn_sequencer #(
    parameter int unsigned CONNECT      = 4,
    parameter int unsigned MATCH_POINTS = 3
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        move_valid,
    input  logic [5:0]  move_cell,
    output logic        move_ready,
    output logic        move_reject,
    input  logic        new_round,
    output logic [63:0] red,
    output logic [63:0] blue,
    output logic        turn,
    output logic [1:0]  p1_score,
    output logic [1:0]  p2_score,
    output logic [1:0]  round_win,
    output logic        match_over,
    output logic        busy
);

    typedef enum logic [2:0] {
        StIdle,
        StPlace,
        StScan,
        StResolve,
        StRoundEnd,
        StMatchEnd
    } state_e;

    // Bit k*8 set for k < n: one vertical run anchored at cell 0.
    function automatic logic [63:0] vert_base(input int unsigned n);
        logic [63:0] m;
        m = '0;
        for (int unsigned k = 0; k < n; k++) begin
            m = m | (64'd1 << (8 * k));
        end
        return m;
    endfunction

    function automatic logic [1:0] sat_inc(input logic [1:0] s);
        return (s == 2'd3) ? 2'd3 : s + 2'd1;
    endfunction

    localparam logic [63:0] HBase = (64'd1 << CONNECT) - 64'd1;
    localparam logic [63:0] VBase = vert_base(CONNECT);

    state_e      state_q, state_d;
    logic [63:0] red_q, red_d, blue_q, blue_d;
    logic        turn_q, turn_d;
    logic [1:0]  p1_q, p1_d, p2_q, p2_d;
    logic [5:0]  cell_q, cell_d;
    logic [5:0]  idx_q, idx_d;
    logic        win_q, win_d;
    logic        reject_q, reject_d;
    logic [1:0]  round_win_q, round_win_d;

    logic [63:0] occupied, plane, hmask, vmask;
    logic [1:0]  mover_score;
    logic        hit;

    // Run detection at the current scan index over the mover's plane.
    always_comb begin
        occupied = red_q | blue_q;
        plane    = turn_q ? blue_q : red_q;
        hmask    = HBase << idx_q;
        vmask    = VBase << idx_q;
        // Column/row limits keep runs from wrapping past the board edge.
        hit = ((32'(idx_q[2:0]) <= 8 - CONNECT) && ((plane & hmask) == hmask)) ||
              ((32'(idx_q[5:3]) <= 8 - CONNECT) && ((plane & vmask) == vmask));
    end

    // Next-state and datapath updates for the round/match sequence.
    always_comb begin
        state_d     = state_q;
        red_d       = red_q;
        blue_d      = blue_q;
        turn_d      = turn_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        cell_d      = cell_q;
        idx_d       = idx_q;
        win_d       = win_q;
        reject_d    = 1'b0;
        round_win_d = 2'b00;
        mover_score = turn_q ? sat_inc(p2_q) : sat_inc(p1_q);

        case (state_q)
            StIdle: begin
                if (move_valid) begin
                    if (occupied[move_cell]) begin
                        reject_d = 1'b1;
                    end else begin
                        cell_d  = move_cell;
                        state_d = StPlace;
                    end
                end
            end
            StPlace: begin
                if (turn_q) blue_d = blue_q | (64'd1 << cell_q);
                else        red_d  = red_q | (64'd1 << cell_q);
                idx_d   = '0;
                win_d   = 1'b0;
                state_d = StScan;
            end
            StScan: begin
                if (hit) win_d = 1'b1;
                idx_d = idx_q + 6'd1;
                if (idx_q == 6'd63) state_d = StResolve;
            end
            StResolve: begin
                if (win_q) begin
                    if (turn_q) begin
                        p2_d        = mover_score;
                        round_win_d = 2'b10;
                    end else begin
                        p1_d        = mover_score;
                        round_win_d = 2'b01;
                    end
                    // Loser opens the next round.
                    turn_d  = ~turn_q;
                    state_d = (32'(mover_score) == MATCH_POINTS) ? StMatchEnd : StRoundEnd;
                end else if (&occupied) begin
                    round_win_d = 2'b11;
                    turn_d      = 1'b0;
                    state_d     = StRoundEnd;
                end else begin
                    turn_d  = ~turn_q;
                    state_d = StIdle;
                end
            end
            StRoundEnd: begin
                if (new_round) begin
                    red_d   = '0;
                    blue_d  = '0;
                    state_d = StIdle;
                end
            end
            StMatchEnd: begin
                if (new_round) begin
                    red_d   = '0;
                    blue_d  = '0;
                    p1_d    = '0;
                    p2_d    = '0;
                    turn_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            red_q       <= '0;
            blue_q      <= '0;
            turn_q      <= 1'b0;
            p1_q        <= '0;
            p2_q        <= '0;
            cell_q      <= '0;
            idx_q       <= '0;
            win_q       <= 1'b0;
            reject_q    <= 1'b0;
            round_win_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            red_q       <= red_d;
            blue_q      <= blue_d;
            turn_q      <= turn_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            cell_q      <= cell_d;
            idx_q       <= idx_d;
            win_q       <= win_d;
            reject_q    <= reject_d;
            round_win_q <= round_win_d;
        end
    end

    assign move_ready  = (state_q == StIdle);
    assign busy        = (state_q == StPlace) || (state_q == StScan) || (state_q == StResolve);
    assign match_over  = (state_q == StMatchEnd);
    assign move_reject = reject_q;
    assign round_win   = round_win_q;
    assign red         = red_q;
    assign blue        = blue_q;
    assign turn        = turn_q;
    assign p1_score    = p1_q;
    assign p2_score    = p2_q;

endmodule

// File: tb/tb_bubble_turn_sequencer.sv
// Directed bench for bubble_turn_sequencer with hand-computed expectations.
module tb_bubble_turn_sequencer;

    logic        CLK;
    logic        reset;
    logic        move_valid;
    logic [5:0]  move_cell;
    logic        move_ready;
    logic        move_reject;
    logic        new_round;
    logic [63:0] red;
    logic [63:0] blue;
    logic        turn;
    logic [1:0]  p1_score;
    logic [1:0]  p2_score;
    logic [1:0]  round_win;
    logic        match_over;
    logic        busy;

    int vectors;
    int miscompares;

    logic [1:0] last_rw;
    logic       last_rej;
    int         last_busy;

    bubble_turn_sequencer #(.CONNECT(4), .MATCH_POINTS(3)) dut (
        .CLK         (CLK),
        .reset       (reset),
        .move_valid  (move_valid),
        .move_cell   (move_cell),
        .move_ready  (move_ready),
        .move_reject (move_reject),
        .new_round   (new_round),
        .red         (red),
        .blue        (blue),
        .turn        (turn),
        .p1_score    (p1_score),
        .p2_score    (p2_score),
        .round_win   (round_win),
        .match_over  (match_over),
        .busy        (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the move finished.
    task automatic play(input logic [5:0] c);
        if (!move_ready) chk("ready_before_move", 64'(move_ready), 64'd1);
        move_valid = 1'b1;
        move_cell  = c;
        @(negedge CLK);
        move_valid = 1'b0;
        last_rej   = move_reject;
        last_busy  = 0;
        while (busy && last_busy < 200) begin
            last_busy++;
            @(negedge CLK);
        end
        if (last_busy >= 200) chk("move_timeout", 64'(last_busy), 64'd66);
        last_rw = round_win;
    endtask

    task automatic pulse_new_round();
        new_round = 1'b1;
        @(negedge CLK);
        new_round = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge CLK);
        reset = 1'b0;
    endtask

    // Blue wins on row 1 (cells 8..11) with red opening.
    task automatic blue_round();
        play(6'd0);  play(6'd8);  play(6'd1);  play(6'd9);
        play(6'd16); play(6'd10); play(6'd17); play(6'd11);
    endtask

    initial begin
        logic [5:0] rcells[$];
        logic [5:0] bcells[$];
        logic [1:0] early;

        vectors     = 0;
        miscompares = 0;
        move_valid  = 1'b0;
        move_cell   = '0;
        new_round   = 1'b0;
        @(negedge CLK);
        do_reset();

        // Reset state
        chk("rst_red", red, 64'd0);
        chk("rst_blue", blue, 64'd0);
        chk("rst_turn", 64'(turn), 64'd0);
        chk("rst_ready", 64'(move_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_scores", 64'({p1_score, p2_score}), 64'd0);
        chk("rst_rw_over", 64'({round_win, match_over, move_reject}), 64'd0);

        // Single red move, latency and result
        play(6'd10);
        chk("m1_busy_cycles", 64'(last_busy), 64'd66);
        chk("m1_red", red, 64'h400);
        chk("m1_rw", 64'(last_rw), 64'd0);
        chk("m1_turn", 64'(turn), 64'd1);
        chk("m1_ready", 64'(move_ready), 64'd1);

        // Blue tries the occupied cell
        play(6'd10);
        chk("rej_pulse", 64'(last_rej), 64'd1);
        chk("rej_busy", 64'(last_busy), 64'd0);
        chk("rej_blue", blue, 64'd0);
        chk("rej_turn", 64'(turn), 64'd1);
        @(negedge CLK);
        chk("rej_one_cycle", 64'(move_reject), 64'd0);

        // Red horizontal win on row 0
        do_reset();
        play(6'd0); play(6'd8); play(6'd1); play(6'd9);
        play(6'd2); play(6'd10);
        chk("h_no_early", 64'(last_rw), 64'd0);
        play(6'd3);
        chk("h_rw", 64'(last_rw), 64'd1);
        chk("h_p1", 64'(p1_score), 64'd1);
        chk("h_turn", 64'(turn), 64'd1);
        chk("h_roundend", 64'({move_ready, busy, match_over}), 64'd0);
        chk("h_red", red, 64'hF);
        @(negedge CLK);
        chk("h_rw_pulse", 64'(round_win), 64'd0);
        pulse_new_round();
        chk("nr_red", red, 64'd0);
        chk("nr_blue", blue, 64'd0);
        chk("nr_ready", 64'(move_ready), 64'd1);
        chk("nr_p1_kept", 64'(p1_score), 64'd1);

        // Row-wrap: red 6,7,8,9 must not win; then blue vertical on column 3
        play(6'd40); play(6'd6); play(6'd41); play(6'd7);
        play(6'd48); play(6'd8); play(6'd50); play(6'd9);
        chk("wrap_rw", 64'(last_rw), 64'd0);
        chk("wrap_ready", 64'(move_ready), 64'd1);
        play(6'd3);  play(6'd20); play(6'd11); play(6'd22);
        play(6'd19); play(6'd30); play(6'd27);
        chk("v_rw", 64'(last_rw), 64'd2);
        chk("v_p2", 64'(p2_score), 64'd1);
        chk("v_turn", 64'(turn), 64'd0);
        pulse_new_round();

        // Blue reaches three round wins
        blue_round();
        chk("b2_p2", 64'(p2_score), 64'd2);
        chk("b2_over", 64'(match_over), 64'd0);
        pulse_new_round();
        blue_round();
        chk("b3_rw", 64'(last_rw), 64'd2);
        chk("b3_p2", 64'(p2_score), 64'd3);
        chk("b3_over", 64'(match_over), 64'd1);
        chk("b3_ready", 64'(move_ready), 64'd0);
        pulse_new_round();
        chk("mr_scores", 64'({p1_score, p2_score}), 64'd0);
        chk("mr_turn", 64'(turn), 64'd0);
        chk("mr_ready_over", 64'({move_ready, match_over}), 64'd2);
        chk("mr_planes", red | blue, 64'd0);

        // Full board draw: rows RRBBRRBB, odd rows shifted by 2
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (((c + ((r % 2) * 2)) % 4) < 2) rcells.push_back(6'(8 * r + c));
                else                               bcells.push_back(6'(8 * r + c));
            end
        end
        early = 2'b00;
        for (int k = 0; k < 32; k++) begin
            play(rcells[k]);
            early = early | last_rw;
            play(bcells[k]);
            if (k < 31) early = early | last_rw;
        end
        chk("full_no_early", 64'(early), 64'd0);
        chk("full_rw", 64'(last_rw), 64'd3);
        chk("full_turn", 64'(turn), 64'd0);
        chk("full_red", red, 64'hCC33CC33CC33CC33);
        chk("full_blue", blue, 64'h33CC33CC33CC33CC);
        chk("full_roundend", 64'({move_ready, busy}), 64'd0);
        pulse_new_round();

        // Reset in the middle of blue's scan
        play(6'd5);
        move_valid = 1'b1;
        move_cell  = 6'd12;
        @(negedge CLK);
        move_valid = 1'b0;
        repeat (20) @(negedge CLK);
        chk("ms_busy", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("ms_planes", red | blue, 64'd0);
        chk("ms_turn", 64'(turn), 64'd0);
        chk("ms_ready_busy", 64'({move_ready, busy}), 64'd2);
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        chk("ms_after", 64'({round_win, move_reject, match_over}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
